// File: rtl/mul_seq_ctrl.sv
// Iterative 32x32->64 shift-and-add multiplier sequencer sharing one 32-bit ripple adder.
// Optional signed support is enabled by defining MUL_SIGNED_EN (adds signed_op port and FIX state).

module ripple_add32 (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [31:0] chain;

  assign chain[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i] = in1[i] ^ in2[i] ^ chain[i];
    if (i < 31) begin : g_carry
      assign chain[i+1] = (in1[i] & in2[i]) | (chain[i] & (in1[i] ^ in2[i]));
    end
  end

endmodule

module mul_seq_ctrl #(
  parameter int CNT_W       = 6,
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
`ifdef MUL_SIGNED_EN
  input  logic        signed_op,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef MUL_SIGNED_EN
    FIX,
`endif
    DONE
  } state_t;

  state_t      state;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] mcand;
  logic [CNT_W-1:0] cnt;

  logic [31:0] add_in2;
  logic [31:0] add_sum;
  logic        add_cout;
  logic [31:0] next_hi;
  logic [31:0] next_lo;
  logic [31:0] load_a;
  logic [31:0] load_b;

  assign add_in2 = acc_lo[0] ? mcand : 32'd0;

  ripple_add32 u_add (
    .in1 (acc_hi),
    .in2 (add_in2),
    .cin (1'b0),
    .sum (add_sum)
  );

  // The shared adder has no carry-out, so recover it from the operand and sum MSBs.
  assign add_cout = (acc_hi[31] & add_in2[31]) |
                    ((acc_hi[31] ^ add_in2[31]) & ~add_sum[31]);

  assign next_hi = {add_cout, add_sum[31:1]};
  assign next_lo = {add_sum[0], acc_lo[31:1]};

`ifdef MUL_SIGNED_EN
  logic negate;
  logic load_neg;

  assign load_a   = (signed_op && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign load_b   = (signed_op && op_b[31]) ? (~op_b + 32'd1) : op_b;
  assign load_neg = signed_op & (op_a[31] ^ op_b[31]);
`else
  assign load_a = op_a;
  assign load_b = op_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 64'd0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
      mcand   <= 32'd0;
      cnt     <= '0;
`ifdef MUL_SIGNED_EN
      negate  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= load_a;
            acc_lo <= load_b;
            acc_hi <= 32'd0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef MUL_SIGNED_EN
            negate <= load_neg;
`endif
          end
        end

        RUN: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(31)) begin
`ifdef MUL_SIGNED_EN
            state   <= FIX;
`else
            // Product is registered from the final step so done and product line up.
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {next_hi, next_lo};
`endif
          end
        end

`ifdef MUL_SIGNED_EN
        FIX: begin
          product <= negate ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= DONE;
        end
`endif

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (!HOLD_RESULT) begin
            product <= 64'd0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed and random operations against an arithmetic model.
// Honours MUL_SIGNED_EN to exercise the signed path and its longer latency.

module tb_mul_seq_ctrl;

`ifdef MUL_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int vectors     = 0;
  int miscompares = 0;

  mul_seq_ctrl #(
    .CNT_W       (6),
    .HOLD_RESULT (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef MUL_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic        [63:0] ua;
    logic        [63:0] ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (sgn) return 64'(sa * sb);
    return ua * ub;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Drives a start request at the current negedge; the next posedge accepts it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    op_a      = a;
    op_b      = b;
    signed_op = sgn;
    start     = 1'b1;
  endtask

  // Counts negedges until done; optionally drops start after acceptance and pulses it mid-run.
  task automatic waitDone(input bit drop_start, input bit mid_pulse,
                          output int n, output int nb);
    n  = 0;
    nb = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1 && drop_start) begin
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
      end
      if (mid_pulse && n == 5) start = 1'b1;
      if (mid_pulse && n == 6) start = 1'b0;
      if (done === 1'b1) break;
      if (busy === 1'b1) nb++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input bit mid_pulse);
    int n;
    int nb;
    logic [63:0] exp;
    exp = refProduct(a, b, sgn);
    applyStimulus(a, b, sgn);
    waitDone(1'b1, mid_pulse, n, nb);
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_latency"}, 64'(n), 64'(LAT));
    checkOutput({tag, "_busy_cycles"}, 64'(nb), 64'(LAT - 1));
    checkOutput({tag, "_product"}, product, exp);
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_hold"}, product, exp);
  endtask

  initial begin
    int n;
    int nb;
    int done_seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    rst       = 1'b1;
    start     = 1'b1;
    op_a      = 32'd7;
    op_b      = 32'd6;
    signed_op = 1'b0;

    // Reset dominates a simultaneous start request.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_product", product, 64'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", 64'(busy), 64'd0);

    runOp("mul7x6", 32'd7, 32'd6, 1'b0, 1'b0);
    runOp("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runOp("zero_a", 32'd0, $urandom, 1'b0, 1'b0);
    runOp("zero_b", $urandom, 32'd0, 1'b0, 1'b1);

    // Start held high across two operations.
    applyStimulus(32'd3, 32'd5, 1'b0);
    waitDone(1'b0, 1'b0, n, nb);
    checkOutput("b2b1_latency", 64'(n), 64'(LAT));
    checkOutput("b2b1_product", product, 64'd15);
    op_a = 32'h0001_0000;
    op_b = 32'h0001_0000;
    @(negedge clk);
    checkOutput("b2b_idle_busy", 64'(busy), 64'd0);
    checkOutput("b2b_idle_done", 64'(done), 64'd0);
    @(negedge clk);
    checkOutput("b2b2_accept", 64'(busy), 64'd1);
    start = 1'b0;
    waitDone(1'b0, 1'b0, n, nb);
    checkOutput("b2b2_latency", 64'(n), 64'(LAT - 1));
    checkOutput("b2b2_product", product, 64'h0000_0001_0000_0000);

    // Reset in the middle of a run aborts without a done pulse.
    @(negedge clk);
    applyStimulus(32'd9, 32'd9, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_product", product, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    checkOutput("abort_quiet", 64'(done_seen), 64'd0);
    runOp("mul2x3", 32'd2, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h0000_0001;
      runOp("rand_u", ra, rb, 1'b0, i[0]);
    end

`ifdef MUL_SIGNED_EN
    runOp("sgn_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    checkOutput("sgn_m3x5_const", product, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp("sgn_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    checkOutput("sgn_minmin_const", product, 64'h4000_0000_0000_0000);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      runOp("rand_s", ra, rb, rs, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
